// File: rtl/lcd_rx_decoder_if.sv
// 4-bit character-LCD write bus plus the decoded byte stream seen by the monitor.
// master drives the LCD pins, slave is the receive-side decoder.
interface lcd_rx_decoder_if;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [3:0] sf_d;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       byte_rs;
    logic       mode4;
    logic       busy;
    logic [5:0] err;
    logic       nib_phase;

    modport master (
        output lcd_e, lcd_rs, lcd_rw, sf_d,
        input  byte_valid, byte_data, byte_rs, mode4, busy, err, nib_phase
    );

    modport slave (
        input  lcd_e, lcd_rs, lcd_rw, sf_d,
        output byte_valid, byte_data, byte_rs, mode4, busy, err, nib_phase
    );
endinterface

// File: rtl/lcd_rx_decoder.sv
// Receive-side decoder and protocol checker for the 4-bit LCD write bus.
//   state  | meaning
//   S_INIT | power-on mode, every E pulse is a single nibble
//   S_HI   | 4-bit mode, expecting the high nibble
//   S_LO   | 4-bit mode, expecting the low nibble
module lcd_rx_decoder #(
    parameter int SETUP_MIN = 2,
    parameter int E_MIN     = 12,
    parameter int NIB_GAP   = 50,
    parameter int CMD_GAP   = 2000,
    parameter int CLR_GAP   = 82000,
    parameter int INIT_SKIP = 1
) (
    input  logic              clk,
    input  logic              reset,
    lcd_rx_decoder_if.slave   bus
);
    localparam int SW = $clog2(SETUP_MIN + 1);
    localparam int EW = $clog2(E_MIN + 1);
    localparam int GW = $clog2(NIB_GAP + 1);
    localparam logic [SW-1:0] SETUP_LIM = SW'(SETUP_MIN);
    localparam logic [EW-1:0] E_LIM     = EW'(E_MIN);
    localparam logic [GW-1:0] GAP_LIM   = GW'(NIB_GAP);
    localparam logic [16:0]   CMD_LD    = 17'(CMD_GAP);
    localparam logic [16:0]   CLR_LD    = 17'(CLR_GAP);

    typedef enum logic [1:0] {S_INIT, S_HI, S_LO} state_t;
    state_t state, state_nx;

    logic          e_q, rs_q;
    logic [3:0]    d_q;
    logic [SW-1:0] stab;
    logic [EW-1:0] e_cnt;
    logic [GW-1:0] gap;
    logic [16:0]   busy_cnt;
    logic          unchk;
    logic [3:0]    hi_nib;
    logic          hi_rs;
    logic          bv_r, br_r;
    logic [7:0]    bd_r;
    logic [5:0]    err_r;

    logic rise, fall, din_chg, busy_now;
    logic cap_init, cap_hi, cap_lo, gap_chk, busy_chk;
    logic [7:0] lo_byte;
    logic is_clr;

    assign din_chg  = {bus.lcd_rs, bus.sf_d} != {rs_q, d_q};
    // A pulse already high when reset is released has no observable rise.
    assign rise     = bus.lcd_e & ~e_q & ~unchk;
    assign fall     = ~bus.lcd_e & e_q;
    assign busy_now = busy_cnt != 17'd0;
    assign lo_byte  = {hi_nib, d_q};
    assign is_clr   = ~hi_rs && (lo_byte == 8'h01);

    always_ff @(posedge clk) begin
        if (!reset)
            state <= (INIT_SKIP != 0) ? S_HI : S_INIT;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_INIT:  if (fall && d_q == 4'h2) state_nx = S_HI;
            S_HI:    if (fall) state_nx = S_LO;
            S_LO:    if (fall) state_nx = S_HI;
            default: state_nx = S_HI;
        endcase
    end

    always_comb begin
        cap_init = 1'b0;
        cap_hi   = 1'b0;
        cap_lo   = 1'b0;
        gap_chk  = 1'b0;
        busy_chk = 1'b0;
        case (state)
            S_INIT: begin
                cap_init = fall;
                busy_chk = rise;
            end
            S_HI: begin
                cap_hi   = fall;
                busy_chk = rise;
            end
            S_LO: begin
                cap_lo   = fall;
                gap_chk  = rise;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            e_q      <= 1'b0;
            rs_q     <= 1'b0;
            d_q      <= 4'h0;
            stab     <= '0;
            e_cnt    <= '0;
            gap      <= '0;
            busy_cnt <= 17'd0;
            unchk    <= 1'b1;
            hi_nib   <= 4'h0;
            hi_rs    <= 1'b0;
            bv_r     <= 1'b0;
            bd_r     <= 8'h00;
            br_r     <= 1'b0;
            err_r    <= 6'h00;
        end else begin
            e_q  <= bus.lcd_e;
            rs_q <= bus.lcd_rs;
            d_q  <= bus.sf_d;
            bv_r <= 1'b0;

            if (!bus.lcd_e) unchk <= 1'b0;

            if (din_chg) stab <= '0;
            else if (stab < SETUP_LIM) stab <= stab + 1'b1;

            // The rise cycle itself counts as the first E-high cycle.
            if (rise) e_cnt <= EW'(1);
            else if (bus.lcd_e && e_cnt < E_LIM) e_cnt <= e_cnt + 1'b1;

            if (cap_hi) gap <= GW'(1);
            else if (gap < GAP_LIM) gap <= gap + 1'b1;

            if (cap_init) busy_cnt <= CMD_LD;
            else if (cap_lo) busy_cnt <= is_clr ? CLR_LD : CMD_LD;
            else if (busy_now) busy_cnt <= busy_cnt - 1'b1;

            if (cap_init) begin
                bv_r <= 1'b1;
                bd_r <= {d_q, 4'h0};
                br_r <= rs_q;
            end
            if (cap_hi) begin
                hi_nib <= d_q;
                hi_rs  <= rs_q;
            end
            if (cap_lo) begin
                bv_r <= 1'b1;
                bd_r <= lo_byte;
                br_r <= hi_rs;
            end

            if (rise && stab < SETUP_LIM)          err_r[0] <= 1'b1;
            if (gap_chk && gap < GAP_LIM)          err_r[0] <= 1'b1;
            if (fall && !unchk && e_cnt < E_LIM)   err_r[1] <= 1'b1;
            if (e_q && bus.lcd_e && din_chg)       err_r[2] <= 1'b1;
            if (busy_chk && busy_now)              err_r[3] <= 1'b1;
            if (cap_lo && rs_q != hi_rs)           err_r[4] <= 1'b1;
            if (bus.lcd_e && bus.lcd_rw)           err_r[5] <= 1'b1;
        end
    end

    assign bus.byte_valid = bv_r;
    assign bus.byte_data  = bd_r;
    assign bus.byte_rs    = br_r;
    assign bus.mode4      = (state != S_INIT);
    assign bus.nib_phase  = (state == S_LO);
    assign bus.busy       = busy_now;
    assign bus.err        = err_r;
endmodule

// File: tb/tb_lcd_rx_decoder.sv
// Directed bench for lcd_rx_decoder: one 4-bit-mode instance and one power-on-mode instance,
// busy times scaled down so the clear-display window stays short.
module tb_lcd_rx_decoder;
    localparam int CMD = 100;
    localparam int CLR = 400;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sel = 1'b0;
    logic       e = 1'b0, rs = 1'b0, rw = 1'b0;
    logic [3:0] d = 4'h0;

    int n_chk = 0, n_err = 0;
    int na = 0, nb = 0;
    logic [7:0] la = 8'h00, lb = 8'h00;
    logic lra = 1'b0;
    int nbusy, base;

    always #5 clk = ~clk;

    lcd_rx_decoder_if a ();
    lcd_rx_decoder_if b ();

    assign a.lcd_e  = e & ~sel;
    assign a.lcd_rs = rs;
    assign a.lcd_rw = rw;
    assign a.sf_d   = d;
    assign b.lcd_e  = e & sel;
    assign b.lcd_rs = rs;
    assign b.lcd_rw = rw;
    assign b.sf_d   = d;

    lcd_rx_decoder #(.CMD_GAP(CMD), .CLR_GAP(CLR), .INIT_SKIP(1)) dut_a (
        .clk(clk), .reset(reset), .bus(a));
    lcd_rx_decoder #(.CMD_GAP(CMD), .CLR_GAP(CLR), .INIT_SKIP(0)) dut_b (
        .clk(clk), .reset(reset), .bus(b));

    always @(negedge clk) begin
        if (a.byte_valid) begin
            na++;
            la  = a.byte_data;
            lra = a.byte_rs;
        end
        if (b.byte_valid) begin
            nb++;
            lb = b.byte_data;
        end
    end

    task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic nib(input logic r, input logic [3:0] v, input int setup, input int ew);
        rs = r;
        d  = v;
        tick(setup);
        e = 1'b1;
        tick(ew);
        e = 1'b0;
    endtask

    task automatic byte_tx(input logic r, input logic [7:0] v, input int setup, input int ew,
                           input int gap);
        nib(r, v[7:4], setup, ew);
        tick(gap - setup);
        nib(r, v[3:0], setup, ew);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    task automatic measure_busy(output int n);
        n = 0;
        tick(1);
        while (a.busy && n < CLR + 10) begin
            n++;
            tick(1);
        end
    endtask

    initial begin
        logic [3:0] init_nib [4];
        init_nib = '{4'h3, 4'h3, 4'h3, 4'h2};

        tick(3);
        chk_val("rst_valid", a.byte_valid, 0);
        chk_val("rst_data",  a.byte_data, 8'h00);
        chk_val("rst_rs",    a.byte_rs, 0);
        chk_val("rst_busy",  a.busy, 0);
        chk_val("rst_err",   a.err, 6'h00);
        chk_val("rst_phase", a.nib_phase, 0);
        chk_val("rst_mode4_a", a.mode4, 1);
        chk_val("rst_mode4_b", b.mode4, 0);
        reset = 1'b1;
        tick(1);

        // power-on nibble mode
        sel = 1'b1;
        for (int i = 0; i < 4; i++) begin
            nib(1'b0, init_nib[i], 3, 12);
            tick(2);
            chk_val("init_cnt",  nb, i + 1);
            chk_val("init_data", lb, {init_nib[i], 4'h0});
            if (i == 2) chk_val("init_mode_pre", b.mode4, 0);
            tick(CMD);
        end
        chk_val("init_mode4", b.mode4, 1);
        byte_tx(1'b0, 8'h28, 3, 12, 50);
        tick(2);
        chk_val("init_cnt28",  nb, 5);
        chk_val("init_data28", lb, 8'h28);
        chk_val("init_err",    b.err, 6'h00);
        tick(CMD);
        sel = 1'b0;

        // nominal byte
        base = na;
        byte_tx(1'b1, 8'h46, 3, 12, 50);
        measure_busy(nbusy);
        chk_val("nom_cnt",  na - base, 1);
        chk_val("nom_data", la, 8'h46);
        chk_val("nom_rs",   lra, 1);
        chk_val("nom_busy", nbusy, CMD);
        chk_val("nom_err",  a.err, 6'h00);

        // clear display busy window
        byte_tx(1'b0, 8'h01, 3, 12, 50);
        measure_busy(nbusy);
        chk_val("clr_busy", nbusy, CLR);
        chk_val("clr_rs",   lra, 0);
        byte_tx(1'b0, 8'h01, 3, 12, 50);
        tick(CLR - 2);
        byte_tx(1'b1, 8'h41, 3, 12, 50);
        tick(2);
        chk_val("clr_edge_err",  a.err, 6'h00);
        chk_val("clr_edge_data", la, 8'h41);
        tick(CMD);
        byte_tx(1'b0, 8'h01, 3, 12, 50);
        tick(CLR - 3);
        byte_tx(1'b1, 8'h42, 3, 12, 50);
        tick(2);
        chk_val("clr_early_err",  a.err, 6'h08);
        chk_val("clr_early_data", la, 8'h42);

        // short E pulse
        do_reset();
        byte_tx(1'b1, 8'h5A, 3, 11, 50);
        tick(2);
        chk_val("short_e_err",  a.err, 6'h02);
        chk_val("short_e_data", la, 8'h5A);

        // data change while E high
        do_reset();
        rs = 1'b1;
        d  = 4'h6;
        tick(3);
        e = 1'b1;
        tick(5);
        d = 4'h7;
        tick(7);
        e = 1'b0;
        tick(2);
        chk_val("hold_err", a.err, 6'h04);

        // data changes one cycle before the rise
        do_reset();
        byte_tx(1'b1, 8'h35, 1, 12, 50);
        tick(2);
        chk_val("setup_err",  a.err, 6'h01);
        chk_val("setup_data", la, 8'h35);

        // low nibble one cycle inside the nibble gap
        do_reset();
        byte_tx(1'b1, 8'h46, 3, 12, 49);
        tick(2);
        chk_val("gap_err", a.err, 6'h01);

        // rs differs between nibbles
        do_reset();
        nib(1'b1, 4'h4, 3, 12);
        tick(47);
        nib(1'b0, 4'h6, 3, 12);
        tick(2);
        chk_val("rs_mis_err", a.err, 6'h10);

        // rw asserted, transfer still decoded
        do_reset();
        rw = 1'b1;
        byte_tx(1'b1, 8'h46, 3, 12, 50);
        rw = 1'b0;
        tick(2);
        chk_val("rw_err",  a.err, 6'h20);
        chk_val("rw_data", la, 8'h46);

        // reset between the nibbles while busy is running
        do_reset();
        byte_tx(1'b1, 8'h21, 3, 12, 50);
        tick(47);
        nib(1'b1, 4'h4, 3, 12);
        tick(3);
        chk_val("mid_pre_phase", a.nib_phase, 1);
        chk_val("mid_pre_busy",  a.busy, 1);
        chk_val("mid_pre_err",   a.err, 6'h08);
        do_reset();
        chk_val("mid_phase", a.nib_phase, 0);
        chk_val("mid_busy",  a.busy, 0);
        chk_val("mid_err",   a.err, 6'h00);
        base = na;
        byte_tx(1'b1, 8'h4B, 3, 12, 50);
        tick(2);
        chk_val("mid_cnt",  na - base, 1);
        chk_val("mid_data", la, 8'h4B);
        chk_val("mid_err2", a.err, 6'h00);

        // E already high at reset release: fall decoded without setup/width checks
        tick(CMD);
        rs = 1'b1;
        d  = 4'h7;
        tick(3);
        e = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(3);
        e = 1'b0;
        tick(2);
        chk_val("ehi_phase", a.nib_phase, 1);
        chk_val("ehi_err",   a.err, 6'h00);
        tick(46);
        nib(1'b1, 4'h2, 3, 12);
        tick(2);
        chk_val("ehi_data", la, 8'h72);
        chk_val("ehi_err2", a.err, 6'h00);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
